// File: rtl/rf_bank_arbiter_pkg.sv
// Shared constants, types and reg-id helpers for the 4-bank operand register file arbiter.
// A reg id splits into bank = low 2 bits and row = upper 3 bits.
package rf_bank_arbiter_pkg;

  localparam int NUM_OC        = 8;
  localparam int NUM_BANKS     = 4;
  localparam int ROW_W         = 3;
  localparam int DATA_W        = 256;
  localparam int OCID_W        = $clog2(NUM_OC);
  localparam int REG_ID_W      = 5;
  localparam int BANK_W        = 2;
  localparam int WR_STREAK_MAX = 4;
  localparam int CREDIT_W      = $clog2(WR_STREAK_MAX + 1);

  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [BANK_W-1:0]   bank_t;
  typedef logic [ROW_W-1:0]    row_t;
  typedef logic [OCID_W-1:0]   ocid_t;
  typedef logic [CREDIT_W-1:0] credit_t;

  typedef enum logic [1:0] {
    ISSUE_IDLE = 2'd0,
    ISSUE_RD   = 2'd1,
    ISSUE_WR   = 2'd2
  } issue_e;

  function automatic bank_t bank_of(reg_id_t r);
    return r[BANK_W-1:0];
  endfunction

  function automatic row_t row_of(reg_id_t r);
    return r[REG_ID_W-1:BANK_W];
  endfunction

endpackage

// File: rtl/rf_bank_arbiter_if.sv
// Request/grant bundle between operand collectors, writeback and the bank arbiter,
// plus the registered per-bank control outputs.
interface rf_bank_arbiter_if;
  import rf_bank_arbiter_pkg::*;

  logic [NUM_OC-1:0]           rd_req;
  logic [NUM_OC*REG_ID_W-1:0]  rd_reg;
  logic [NUM_OC-1:0]           rd_gnt;
  logic                        wb_valid;
  logic [REG_ID_W-1:0]         wb_reg;
  logic [DATA_W-1:0]           wb_data;
  logic                        wb_ready;
  logic [NUM_BANKS*ROW_W-1:0]  rf_addr;
  logic [NUM_BANKS-1:0]        rf_wr;
  logic [NUM_BANKS*DATA_W-1:0] rf_wdata;
  logic [NUM_BANKS*OCID_W-1:0] rf_ocid;
  logic [NUM_BANKS-1:0]        rf_rd_en;

  modport master (
    output rd_req, rd_reg, wb_valid, wb_reg, wb_data,
    input  rd_gnt, wb_ready, rf_addr, rf_wr, rf_wdata, rf_ocid, rf_rd_en
  );

  modport slave (
    input  rd_req, rd_reg, wb_valid, wb_reg, wb_data,
    output rd_gnt, wb_ready, rf_addr, rf_wr, rf_wdata, rf_ocid, rf_rd_en
  );

endinterface

// File: rtl/rf_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating start pointer; one-hot grant plus encoded index.
// The pointer moves past the winner only when the caller says the grant was used.
module rr_arbiter
  import rf_bank_arbiter_pkg::*;
#(
  parameter int N = NUM_OC,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             adv,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             valid
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv && valid) begin
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rf_bank_arbiter.sv
// Per-bank scheduler: decodes collector reads and the writeback to banks, resolves
// write-vs-read with a bounded write streak, and registers each bank's control inputs.
module rf_bank_arbiter
  import rf_bank_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rf_bank_arbiter_if.slave   bus
);

  logic [NUM_OC-1:0] pend      [NUM_BANKS];
  logic [NUM_OC-1:0] arb_gnt   [NUM_BANKS];
  ocid_t             arb_idx   [NUM_BANKS];
  logic              arb_valid [NUM_BANKS];
  issue_e            issue     [NUM_BANKS];
  credit_t           credit    [NUM_BANKS];
  logic [NUM_OC-1:0] gnt_c;
  logic              wb_ready_c;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_OC; i++) begin
        pend[b][i] = bus.rd_req[i] &&
                     (bank_of(bus.rd_reg[i*REG_ID_W +: REG_ID_W]) == bank_t'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_arb
    rr_arbiter #(.N(NUM_OC)) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (pend[b]),
      .adv     (issue[b] == ISSUE_RD),
      .gnt     (arb_gnt[b]),
      .gnt_idx (arb_idx[b]),
      .valid   (arb_valid[b])
    );
  end

  // credit counts down the writes a waiting read still tolerates; at zero the read goes first
  always_comb begin
    gnt_c      = '0;
    wb_ready_c = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      logic wb_hit;
      logic force_rd;
      wb_hit   = bus.wb_valid && (bank_of(bus.wb_reg) == bank_t'(b));
      force_rd = wb_hit && arb_valid[b] && (credit[b] == '0);
      issue[b] = ISSUE_IDLE;
      if (wb_hit && !force_rd) begin
        issue[b]   = ISSUE_WR;
        wb_ready_c = 1'b1;
      end else if (arb_valid[b]) begin
        issue[b] = ISSUE_RD;
        gnt_c    = gnt_c | arb_gnt[b];
      end
    end
  end

  assign bus.rd_gnt   = rst_n ? gnt_c : '0;
  assign bus.wb_ready = rst_n && wb_ready_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        credit[b] <= credit_t'(WR_STREAK_MAX);
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (issue[b] == ISSUE_WR && arb_valid[b]) begin
          credit[b] <= (credit[b] == '0) ? '0 : credit[b] - 1'b1;
        end else if (!arb_valid[b] || issue[b] == ISSUE_RD) begin
          credit[b] <= credit_t'(WR_STREAK_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rf_addr  <= '0;
      bus.rf_wr    <= '0;
      bus.rf_wdata <= '0;
      bus.rf_ocid  <= '0;
      bus.rf_rd_en <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bus.rf_wr[b]    <= 1'b0;
        bus.rf_rd_en[b] <= 1'b0;
        case (issue[b])
          ISSUE_WR: begin
            bus.rf_wr[b]                       <= 1'b1;
            bus.rf_addr[b*ROW_W +: ROW_W]      <= row_of(bus.wb_reg);
            bus.rf_wdata[b*DATA_W +: DATA_W]   <= bus.wb_data;
          end
          ISSUE_RD: begin
            bus.rf_rd_en[b]                    <= 1'b1;
            bus.rf_addr[b*ROW_W +: ROW_W]      <=
              row_of(bus.rd_reg[int'(arb_idx[b])*REG_ID_W +: REG_ID_W]);
            bus.rf_ocid[b*OCID_W +: OCID_W]    <= arb_idx[b];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// Directed bench for rf_bank_arbiter with hand-computed expectations and a tiny bank model
// that returns read data and owner id two cycles after the grant.
module tb_rf_bank_arbiter;
  import rf_bank_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rf_bank_arbiter_if bus();

  rf_bank_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem      [NUM_BANKS][8];
  logic [DATA_W-1:0] dout     [NUM_BANKS];
  logic [OCID_W-1:0] ret_ocid [NUM_BANKS];

  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bus.rf_wr[b])
        mem[b][bus.rf_addr[b*ROW_W +: ROW_W]] <= bus.rf_wdata[b*DATA_W +: DATA_W];
      if (bus.rf_rd_en[b]) begin
        dout[b]     <= mem[b][bus.rf_addr[b*ROW_W +: ROW_W]];
        ret_ocid[b] <= bus.rf_ocid[b*OCID_W +: OCID_W];
      end
    end
  end

  localparam logic [DATA_W-1:0] D1 = {8{32'hA5A5_0001}};
  localparam logic [DATA_W-1:0] D2 = {8{32'h1E1E_0002}};

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rd_req   = '0;
    bus.rd_reg   = '0;
    bus.wb_valid = 1'b0;
    bus.wb_reg   = '0;
    bus.wb_data  = '0;
  endtask

  task automatic set_rd(input int i, input logic [4:0] r);
    bus.rd_req[i]              = 1'b1;
    bus.rd_reg[i*REG_ID_W +: 5] = r;
  endtask

  task automatic set_wb(input logic [4:0] r, input logic [DATA_W-1:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_reg   = r;
    bus.wb_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    for (int i = 0; i < NUM_OC; i++) set_rd(i, 5'(i + 4));
    set_wb(5'h00, D1);
    #1;
    check("rst_gnt", NUM_OC'(bus.rd_gnt), '0);
    check("rst_wbr", bus.wb_ready, 1'b0);
    step();
    step();
    check("rst_wr",    bus.rf_wr, '0);
    check("rst_rden",  bus.rf_rd_en, '0);
    check("rst_addr",  bus.rf_addr, '0);
    check("rst_ocid",  bus.rf_ocid, '0);
    check("rst_wdata", |bus.rf_wdata, 1'b0);

    // release with reads OCi -> reg i+4: OC0..3 win banks 0..3, row 1
    @(negedge clk);
    rst_n        = 1'b1;
    bus.wb_valid = 1'b0;
    #1;
    check("rel_gnt", bus.rd_gnt, 8'h0F);
    check("rel_wbr", bus.wb_ready, 1'b0);
    step();
    check("nc_rden", bus.rf_rd_en, 4'hF);
    check("nc_wr",   bus.rf_wr, 4'h0);
    check("nc_addr", bus.rf_addr, 12'h249);
    check("nc_ocid", bus.rf_ocid, 12'h688);

    @(negedge clk);
    idle_inputs();
    #1;
    check("idle_gnt", bus.rd_gnt, 8'h00);
    step();
    check("idle_rden", bus.rf_rd_en, 4'h0);
    check("idle_addr", bus.rf_addr, 12'h249);
    check("idle_ocid", bus.rf_ocid, 12'h688);

    // round robin on bank 2: OC1, OC3, OC5 held on reg 0x02
    do_reset();
    begin
      logic [7:0] exp_g [4];
      logic [2:0] exp_o [4];
      exp_g = '{8'h02, 8'h08, 8'h20, 8'h02};
      exp_o = '{3'd1, 3'd3, 3'd5, 3'd1};
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        idle_inputs();
        set_rd(1, 5'h02);
        set_rd(3, 5'h02);
        set_rd(5, 5'h02);
        #1;
        check($sformatf("rr_gnt%0d", c), bus.rd_gnt, exp_g[c]);
        step();
        check($sformatf("rr_ocid%0d", c), bus.rf_ocid[2*OCID_W +: OCID_W], exp_o[c]);
        check($sformatf("rr_rden%0d", c), bus.rf_rd_en, 4'h4);
      end
    end
    // pointer now sits at 2: OC2 beats OC1
    @(negedge clk);
    idle_inputs();
    set_rd(1, 5'h02);
    set_rd(2, 5'h02);
    #1;
    check("rr_ptr", bus.rd_gnt, 8'h04);
    step();

    // write streak: wb reg 0x01 vs OC4 reg 0x09 on bank 1
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      set_wb(5'h01, D1);
      set_rd(4, 5'h09);
      #1;
      check($sformatf("ws_wbr%0d", c), bus.wb_ready, 1'b1);
      check($sformatf("ws_gnt%0d", c), bus.rd_gnt, 8'h00);
      step();
      check($sformatf("ws_wr%0d", c), bus.rf_wr, 4'h2);
    end
    @(negedge clk);
    #1;
    check("ws5_wbr", bus.wb_ready, 1'b0);
    check("ws5_gnt", bus.rd_gnt, 8'h10);
    step();
    check("ws5_rden", bus.rf_rd_en, 4'h2);
    check("ws5_wr",   bus.rf_wr, 4'h0);
    check("ws5_addr", bus.rf_addr[1*ROW_W +: ROW_W], 3'd2);
    check("ws5_ocid", bus.rf_ocid[1*OCID_W +: OCID_W], 3'd4);
    @(negedge clk);
    bus.rd_req[4] = 1'b0;
    #1;
    check("ws6_wbr", bus.wb_ready, 1'b1);
    step();
    check("ws6_wr",    bus.rf_wr, 4'h2);
    check("ws6_addr",  bus.rf_addr[1*ROW_W +: ROW_W], 3'd0);
    check("ws6_wdata", bus.rf_wdata[1*DATA_W +: DATA_W], D1);

    // mixed banks: wb 0x03, OC0 0x0B (bank 3, loses), OC7 0x00 (bank 0)
    @(negedge clk);
    idle_inputs();
    set_wb(5'h03, D2);
    set_rd(0, 5'h0B);
    set_rd(7, 5'h00);
    #1;
    check("mx_wbr", bus.wb_ready, 1'b1);
    check("mx_gnt", bus.rd_gnt, 8'h80);
    step();
    check("mx_wr",   bus.rf_wr, 4'h8);
    check("mx_rden", bus.rf_rd_en, 4'h1);
    check("mx_ocid", bus.rf_ocid[0 +: OCID_W], 3'd7);

    // write reg 0x1E then read it from OC6; data and owner return two cycles after grant
    @(negedge clk);
    idle_inputs();
    set_wb(5'h1E, D2);
    #1;
    check("lt_wbr", bus.wb_ready, 1'b1);
    step();
    check("lt_wr",    bus.rf_wr, 4'h4);
    check("lt_waddr", bus.rf_addr[2*ROW_W +: ROW_W], 3'd7);
    @(negedge clk);
    idle_inputs();
    set_rd(6, 5'h1E);
    #1;
    check("lt_gnt", bus.rd_gnt, 8'h40);
    step();
    check("lt_rden", bus.rf_rd_en, 4'h4);
    check("lt_addr", bus.rf_addr[2*ROW_W +: ROW_W], 3'd7);
    check("lt_ocid", bus.rf_ocid[2*OCID_W +: OCID_W], 3'd6);
    @(negedge clk);
    idle_inputs();
    step();
    check("lt_ret_ocid", ret_ocid[2], 3'd6);
    check("lt_ret_data", dout[2], D2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
